// File: rtl/kangaroo_video_pkg.sv
// Shared types and default raster constants for the video timebase.
package kangaroo_video_pkg;

  typedef enum logic [1:0] {
    BPORCH = 2'd0,
    ACTIVE = 2'd1,
    FPORCH = 2'd2,
    SYNC   = 2'd3
  } axis_state_t;

  localparam logic [8:0] TC_9B = 9'd511;

  localparam logic [8:0] H_PRELOAD_DEF    = 9'd128;
  localparam logic [8:0] HACT_START_DEF   = 9'd136;
  localparam logic [8:0] HBLANK_START_DEF = 9'd392;
  localparam logic [8:0] HSYNC_START_DEF  = 9'd416;
  localparam logic [8:0] HSYNC_END_DEF    = 9'd448;

  localparam logic [8:0] V_PRELOAD_DEF    = 9'd248;
  localparam logic [8:0] VACT_START_DEF   = 9'd264;
  localparam logic [8:0] VBLANK_START_DEF = 9'd504;
  localparam logic [8:0] VSYNC_START_DEF  = 9'd506;
  localparam logic [8:0] VSYNC_END_DEF    = 9'd509;

endpackage

// File: rtl/video_axis_ctrl.sv
// One raster axis: 9-bit up-counter with preload at terminal count, plus region FSM.
//   state  | meaning
//   BPORCH | back porch, also the state after preload/reset
//   ACTIVE | visible region, blank deasserted
//   FPORCH | front porch
//   SYNC   | sync pulse, sync_n low
module video_axis_ctrl
  import kangaroo_video_pkg::*;
#(
  parameter logic [8:0] PRELOAD     = H_PRELOAD_DEF,
  parameter logic [8:0] ACT_START   = HACT_START_DEF,
  parameter logic [8:0] BLANK_START = HBLANK_START_DEF,
  parameter logic [8:0] SYNC_START  = HSYNC_START_DEF,
  parameter logic [8:0] SYNC_END    = HSYNC_END_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [8:0] count,
  output logic       rco,
  output logic       blank,
  output logic       sync_n
);

  if (!((PRELOAD <= ACT_START) && (ACT_START < BLANK_START) &&
        (BLANK_START < SYNC_START) && (SYNC_START < SYNC_END) &&
        (SYNC_END <= TC_9B))) begin : g_bad_params
    $error("video_axis_ctrl: illegal timing parameter ordering");
  end

  logic [8:0]  count_q, count_d;
  axis_state_t state_q, state_d;

  assign rco = en & (count_q == TC_9B);

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    if (en) begin
      if (count_q == TC_9B) begin
        count_d = PRELOAD;
        state_d = BPORCH;
      end else begin
        count_d = count_q + 9'd1;
        // transitions look at the new count so outputs track it with no lag
        unique case (state_q)
          BPORCH: if (count_d == ACT_START)   state_d = ACTIVE;
          ACTIVE: if (count_d == BLANK_START) state_d = FPORCH;
          FPORCH: if (count_d == SYNC_START)  state_d = SYNC;
          SYNC:   if (count_d == SYNC_END)    state_d = BPORCH;
          default:                            state_d = BPORCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= PRELOAD;
      state_q <= BPORCH;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign count  = count_q;
  assign blank  = (state_q != ACTIVE);
  assign sync_n = (state_q != SYNC);

endmodule

// File: rtl/kangaroo_video_timing_ctrl.sv
// Video timebase: cascaded H/V axis controllers with ripple carry and frame-start strobe.
module kangaroo_video_timing_ctrl
  import kangaroo_video_pkg::*;
#(
  parameter logic [8:0] H_PRELOAD    = H_PRELOAD_DEF,
  parameter logic [8:0] HACT_START   = HACT_START_DEF,
  parameter logic [8:0] HBLANK_START = HBLANK_START_DEF,
  parameter logic [8:0] HSYNC_START  = HSYNC_START_DEF,
  parameter logic [8:0] HSYNC_END    = HSYNC_END_DEF,
  parameter logic [8:0] V_PRELOAD    = V_PRELOAD_DEF,
  parameter logic [8:0] VACT_START   = VACT_START_DEF,
  parameter logic [8:0] VBLANK_START = VBLANK_START_DEF,
  parameter logic [8:0] VSYNC_START  = VSYNC_START_DEF,
  parameter logic [8:0] VSYNC_END    = VSYNC_END_DEF
) (
  input  logic       _CLK,
  input  logic       _CLR,
  input  logic       _PCE,
  output logic [8:0] _HCNT,
  output logic [8:0] _VCNT,
  output logic       _HSYNC,
  output logic       _VSYNC,
  output logic       _HBLANK,
  output logic       _VBLANK,
  output logic       _HRCO,
  output logic       _VRCO,
  output logic       _FSTART
);

  logic hrco, vrco;
  logic fstart_q, fstart_d;

  video_axis_ctrl #(
    .PRELOAD(H_PRELOAD), .ACT_START(HACT_START), .BLANK_START(HBLANK_START),
    .SYNC_START(HSYNC_START), .SYNC_END(HSYNC_END)
  ) u_h_axis (
    .clk(_CLK), .rst_n(_CLR), .en(_PCE),
    .count(_HCNT), .rco(hrco), .blank(_HBLANK), .sync_n(_HSYNC)
  );

  // V axis steps once per line, on the H carry
  video_axis_ctrl #(
    .PRELOAD(V_PRELOAD), .ACT_START(VACT_START), .BLANK_START(VBLANK_START),
    .SYNC_START(VSYNC_START), .SYNC_END(VSYNC_END)
  ) u_v_axis (
    .clk(_CLK), .rst_n(_CLR), .en(hrco),
    .count(_VCNT), .rco(vrco), .blank(_VBLANK), .sync_n(_VSYNC)
  );

  always_comb begin
    fstart_d = fstart_q;
    if (_PCE) fstart_d = vrco;
  end

  always_ff @(posedge _CLK or negedge _CLR) begin
    if (!_CLR) fstart_q <= 1'b0;
    else       fstart_q <= fstart_d;
  end

  assign _HRCO   = hrco;
  assign _VRCO   = vrco;
  assign _FSTART = fstart_q;

endmodule

// File: tb/tb_kangaroo_video_timing_ctrl.sv
// Bench for kangaroo_video_timing_ctrl: vector table, directed corners, random _PCE vs range model.
module tb_kangaroo_video_timing_ctrl;

  // H axis at its defaults; V axis shortened to a 16-line frame so frame wraps fit the run.
  localparam int H_PRE = 128, HACT = 136, HBLK = 392, HSYN = 416, HSEND = 448;
  localparam int V_PRE = 496, VACT = 498, VBLK = 504, VSYN = 506, VSEND = 509;

  logic       clk, clr, pce;
  logic [8:0] hcnt, vcnt;
  logic       hsync, vsync, hblank, vblank, hrco, vrco, fstart;

  kangaroo_video_timing_ctrl #(
    .V_PRELOAD(9'(V_PRE)), .VACT_START(9'(VACT)), .VBLANK_START(9'(VBLK)),
    .VSYNC_START(9'(VSYN)), .VSYNC_END(9'(VSEND))
  ) dut (
    ._CLK(clk), ._CLR(clr), ._PCE(pce),
    ._HCNT(hcnt), ._VCNT(vcnt), ._HSYNC(hsync), ._VSYNC(vsync),
    ._HBLANK(hblank), ._VBLANK(vblank), ._HRCO(hrco), ._VRCO(vrco), ._FSTART(fstart)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model: raw counts, regions derived from range rules
  int m_h, m_v;
  bit m_fs;
  int clk_idx, last_hrco_idx, last_period, hrco_seen;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_h = H_PRE; m_v = V_PRE; m_fs = 1'b0;
  endtask

  task automatic model_step(input bit p);
    if (p) begin
      if (m_h == 511) begin
        m_h  = H_PRE;
        m_fs = (m_v == 511);
        m_v  = (m_v == 511) ? V_PRE : m_v + 1;
      end else begin
        m_h  = m_h + 1;
        m_fs = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("hcnt",   int'(hcnt),   m_h);
    chk("vcnt",   int'(vcnt),   m_v);
    chk("hblank", int'(hblank), int'(!(m_h >= HACT && m_h < HBLK)));
    chk("hsync",  int'(hsync),  int'(!(m_h >= HSYN && m_h < HSEND)));
    chk("vblank", int'(vblank), int'(!(m_v >= VACT && m_v < VBLK)));
    chk("vsync",  int'(vsync),  int'(!(m_v >= VSYN && m_v < VSEND)));
    chk("fstart", int'(fstart), int'(m_fs));
  endtask

  // drive one clock with the given enable; carries checked before the edge, state after
  task automatic cycle(input bit p);
    pce = p;
    #1;
    chk("hrco", int'(hrco), int'(p && m_h == 511));
    chk("vrco", int'(vrco), int'(p && m_h == 511 && m_v == 511));
    if (hrco) begin
      if (last_hrco_idx >= 0) last_period = clk_idx - last_hrco_idx;
      last_hrco_idx = clk_idx;
      hrco_seen++;
    end
    @(posedge clk);
    clk_idx++;
    model_step(p);
    #1;
    check_outputs();
  endtask

  typedef struct {
    bit p;
    int exp_h;
    int exp_v;
    bit exp_hblank;
    bit exp_hsync;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int hs_low, hb_low, guard, fs_rise;
    bit prev_fs;

    vecs[0]  = '{1'b1, 129, V_PRE, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 129, V_PRE, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 130, V_PRE, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 131, V_PRE, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 132, V_PRE, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 133, V_PRE, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 133, V_PRE, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 134, V_PRE, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 135, V_PRE, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 136, V_PRE, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 137, V_PRE, 1'b0, 1'b1};

    clk_idx = 0; last_hrco_idx = -1; last_period = 0; hrco_seen = 0;
    clr = 1'b0; pce = 1'b0;
    model_reset();
    #12;
    chk("rst_hcnt",   int'(hcnt),   128);
    chk("rst_vcnt",   int'(vcnt),   V_PRE);
    chk("rst_hsync",  int'(hsync),  1);
    chk("rst_vsync",  int'(vsync),  1);
    chk("rst_hblank", int'(hblank), 1);
    chk("rst_vblank", int'(vblank), 1);
    chk("rst_fstart", int'(fstart), 0);
    @(posedge clk); #2 clr = 1'b1;

    for (int i = 0; i < 11; i++) begin
      cycle(vecs[i].p);
      chk("vec_hcnt",   int'(hcnt),   vecs[i].exp_h);
      chk("vec_vcnt",   int'(vcnt),   vecs[i].exp_v);
      chk("vec_hblank", int'(hblank), int'(vecs[i].exp_hblank));
      chk("vec_hsync",  int'(hsync),  int'(vecs[i].exp_hsync));
    end

    // asynchronous reset mid-line at H=300
    while (m_h != 300) cycle(1'b1);
    #3 clr = 1'b0;
    #1;
    chk("arst_hcnt",   int'(hcnt),   128);
    chk("arst_vcnt",   int'(vcnt),   V_PRE);
    chk("arst_hblank", int'(hblank), 1);
    chk("arst_hsync",  int'(hsync),  1);
    model_reset();
    @(posedge clk); #2 clr = 1'b1;
    cycle(1'b1);
    chk("arst_first_edge", int'(hcnt), 129);

    // one full line from just after a wrap: region widths and a single carry
    guard = 0;
    while (m_h != H_PRE && guard < 1000) begin cycle(1'b1); guard++; end
    chk("line_align", m_h, H_PRE);
    hs_low = 0; hb_low = 0; hrco_seen = 0;
    for (int i = 0; i < 384; i++) begin
      cycle(1'b1);
      if (!hsync) hs_low++;
      if (!hblank) hb_low++;
    end
    chk("hsync_width", hs_low, 32);
    chk("hactive_width", hb_low, 256);
    chk("hrco_per_line", hrco_seen, 1);
    last_hrco_idx = -1; last_period = 0;
    for (int i = 0; i < 800; i++) cycle(1'b1);
    chk("line_period", last_period, 384);

    // _PCE toggling halves the pixel rate
    last_hrco_idx = -1; last_period = 0;
    for (int i = 0; i < 1600; i++) cycle(1'(i % 2));
    chk("line_period_half_rate", last_period, 768);

    // random enable until two frame starts are seen
    fs_rise = 0; prev_fs = fstart; guard = 0;
    while (fs_rise < 2 && guard < 40000) begin
      cycle($urandom_range(0, 3) != 0);
      if (fstart && !prev_fs) fs_rise++;
      prev_fs = fstart;
      guard++;
    end
    chk("frames_seen", fs_rise, 2);

    // simultaneous H/V wrap
    guard = 0;
    while (!(m_h == 511 && m_v == 511) && guard < 8000) begin cycle(1'b1); guard++; end
    chk("reach_511_511", int'(m_h == 511 && m_v == 511), 1);
    cycle(1'b1);
    chk("wrap_hcnt",   int'(hcnt),   128);
    chk("wrap_vcnt",   int'(vcnt),   V_PRE);
    chk("wrap_hblank", int'(hblank), 1);
    chk("wrap_vblank", int'(vblank), 1);
    chk("wrap_fstart", int'(fstart), 1);
    cycle(1'b1);
    chk("fstart_one_clock", int'(fstart), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
